noisy_signal_ma_filter: RTL and testbench

//  Self-contained demo block for the moving-average filter experiment.
//  - Generates a 10-bit triangle test waveform.
//  - Optionally corrupts it with scaled pseudo-random noise.
//  - Smooths the noisy stream with a power-of-two sliding-window moving average.
//  - Exposes both the noisy and the filtered sample every clock.

---
 rtl/noisy_ma_pkg.sv | 35 +++
 rtl/ma_window_core.sv | 38 +++
 rtl/noisy_signal_ma_filter.sv | 94 +++++++++
 tb/tb_noisy_signal_ma_filter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noisy_ma_pkg.sv
// rtl/noisy_ma_pkg.sv - shared constants, types and clamp helper for the noisy moving-average demo
// Purpose: default widths, LFSR seed/taps, triangle direction type and the
//          saturating clamp used on the noisy sample.
// Ports:   none (package)
package noisy_ma_pkg;

  localparam int DATA_W_DEF   = 10;
  localparam int WIN_LOG2_DEF = 3;

  // Wide enough to hold tri_cnt + noise (-240..1248) without wrapping.
  localparam int CALC_W = 16;

  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Saturate a signed value into 0..hi; never wraps.
  function automatic logic [CALC_W-1:0] sat_clamp(input logic signed [CALC_W-1:0] v,
                                                   input logic signed [CALC_W-1:0] hi);
    logic [CALC_W-1:0] r;
    if (v < 0)
      r = '0;
    else if (v > hi)
      r = hi;
    else
      r = v;
    return r;
  endfunction

endpackage

// File: rtl/ma_window_core.sv
// rtl/ma_window_core.sv - sliding-window running-sum moving average
// Purpose: keeps the last 2**WIN_LOG2 input samples and their running sum;
//          dout is the floor of the window mean.
// Ports:   clk   - clock
//          reset - synchronous active-low reset
//          din   - new sample, taken every cycle
//          dout  - floor(mean of the previous N din values)
module ma_window_core #(
  parameter int DATA_W   = 10,
  parameter int WIN_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_W + WIN_LOG2;

  logic [DATA_W-1:0] taps [N];
  logic [SUM_W-1:0]  sum_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) taps[i] <= '0;
      sum_q <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
      // The oldest tap leaves as din enters, so the sum stays within N*max.
      sum_q <= sum_q + SUM_W'(din) - SUM_W'(taps[N-1]);
    end
  end

  assign dout = DATA_W'(sum_q >> WIN_LOG2);

endmodule

// File: rtl/noisy_signal_ma_filter.sv
// rtl/noisy_signal_ma_filter.sv - triangle source with optional LFSR noise and moving-average filter
// Purpose: generates a 10-bit triangle, adds scaled pseudo-random noise when
//          enabled, clamps, registers it and smooths it with ma_window_core.
// Ports:   clk          - clock
//          reset        - synchronous active-low reset
//          noise_en     - 1 adds noise to the waveform
//          noise_level  - noise gain 0..15
//          signal       - registered noisy sample
//          filtered_out - moving average of the last N signal samples
module noisy_signal_ma_filter
  import noisy_ma_pkg::*;
#(
  parameter int          DATA_W    = DATA_W_DEF,
  parameter int          WIN_LOG2  = WIN_LOG2_DEF,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              noise_en,
  input  logic [3:0]        noise_level,
  output logic [DATA_W-1:0] signal,
  output logic [DATA_W-1:0] filtered_out
);

  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]        tri_cnt;
  dir_e                     dir;
  logic [15:0]              lfsr;
  logic signed [4:0]        lfsr_s;
  logic signed [5:0]        gain;
  logic signed [CALC_W-1:0] noise;
  logic signed [CALC_W-1:0] raw;
  logic [DATA_W-1:0]        signal_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tri_cnt <= '0;
      dir     <= DIR_UP;
    end else if (dir == DIR_UP) begin
      if (tri_cnt == CNT_MAX) begin
        tri_cnt <= CNT_MAX - 1'b1;
        dir     <= DIR_DOWN;
      end else begin
        tri_cnt <= tri_cnt + 1'b1;
      end
    end else begin
      if (tri_cnt == '0) begin
        tri_cnt <= DATA_W'(1);
        dir     <= DIR_UP;
      end else begin
        tri_cnt <= tri_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  // Low five LFSR bits read as a two's-complement value, scaled by the gain.
  assign lfsr_s = lfsr[4:0];
  assign gain   = {1'b0, noise_level};

  always_comb begin
    noise = '0;
    if (noise_en)
      noise = CALC_W'(lfsr_s) * CALC_W'(gain);
  end

  assign raw      = $signed({{(CALC_W-DATA_W){1'b0}}, tri_cnt}) + noise;
  assign signal_d = DATA_W'(sat_clamp(raw, $signed({{(CALC_W-DATA_W){1'b0}}, CNT_MAX})));

  always_ff @(posedge clk) begin
    if (!reset)
      signal <= '0;
    else
      signal <= signal_d;
  end

  ma_window_core #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .din   (signal),
    .dout  (filtered_out)
  );

endmodule

// File: tb/tb_noisy_signal_ma_filter.sv
// tb/tb_noisy_signal_ma_filter.sv - self-checking bench for noisy_signal_ma_filter
module tb_noisy_signal_ma_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       noise_en = 1'b0;
  logic [3:0] noise_level = 4'd0;
  logic [9:0] signal;
  logic [9:0] filtered_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noisy_signal_ma_filter dut (
    .clk          (clk),
    .reset        (rst_n),
    .noise_en     (noise_en),
    .noise_level  (noise_level),
    .signal       (signal),
    .filtered_out (filtered_out)
  );

  // Reference model: time-indexed triangle, integer LFSR, queue of past samples.
  int m_t;
  int m_lfsr;
  int m_sig;
  int m_sig_t;
  int m_clean;
  int m_filt;
  int m_clean_filt;
  int hist[$];
  int clean_hist[$];

  function automatic int tri_of(int t);
    int p;
    p = t % 2046;
    return (p <= 1023) ? p : 2046 - p;
  endfunction

  function automatic int lfsr_next(int x);
    int b;
    b = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return ((x << 1) | b) & 16'hFFFF;
  endfunction

  task automatic step();
    int n;
    int v;
    int r;
    int s;
    int cs;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_t = 0; m_lfsr = 16'hACE1; m_sig = 0; m_sig_t = -1; m_clean = 0;
      hist.delete(); clean_hist.delete();
      repeat (8) begin hist.push_back(0); clean_hist.push_back(0); end
    end else begin
      n = 0;
      if (noise_en) begin
        r = m_lfsr & 31;
        if (r >= 16) r = r - 32;
        n = r * int'(noise_level);
      end
      hist.push_back(m_sig);         void'(hist.pop_front());
      clean_hist.push_back(m_clean); void'(clean_hist.pop_front());
      m_clean = tri_of(m_t);
      v = m_clean + n;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      m_sig = v;
      m_sig_t = m_t;
      m_t++;
      m_lfsr = lfsr_next(m_lfsr);
    end
    s = 0; cs = 0;
    foreach (hist[i]) begin s += hist[i]; cs += clean_hist[i]; end
    m_filt = s / 8;
    m_clean_filt = cs / 8;
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    noise_en = 1'b0; noise_level = 4'd0;
    do_reset(2);
    n_cmp++;
    if (signal !== 10'd0) begin n_err++; $display("FAIL reset_signal: got %0d expected 0", signal); end
    n_cmp++;
    if (filtered_out !== 10'd0) begin n_err++; $display("FAIL reset_filtered: got %0d expected 0", filtered_out); end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (signal !== 10'(i)) begin n_err++; $display("FAIL ramp_start: cycle %0d got %0d expected %0d", i, signal, i); end
      n_cmp++;
      if (filtered_out !== 10'(m_filt)) begin n_err++; $display("FAIL ramp_start_filt: cycle %0d got %0d expected %0d", i, filtered_out, m_filt); end
    end
  endtask

  task automatic test_ramp_filter();
    noise_en = 1'b0;
    do_reset(1);
    while (m_t < 2060) begin
      step();
      n_cmp++;
      if (signal !== 10'(m_sig)) begin n_err++; $display("FAIL ramp_signal: t %0d got %0d expected %0d", m_sig_t, signal, m_sig); end
      n_cmp++;
      if (filtered_out !== 10'(m_filt)) begin n_err++; $display("FAIL ramp_filt: t %0d got %0d expected %0d", m_sig_t, filtered_out, m_filt); end
      if (m_sig_t >= 9 && m_sig_t <= 1023) begin
        n_cmp++;
        if (filtered_out !== 10'(m_sig - 5)) begin n_err++; $display("FAIL rise_lag: t %0d got %0d expected %0d", m_sig_t, filtered_out, m_sig - 5); end
      end else if (m_sig_t - 8 >= 1023 && m_sig_t <= 2046) begin
        n_cmp++;
        if (filtered_out !== 10'(m_sig + 4)) begin n_err++; $display("FAIL fall_lag: t %0d got %0d expected %0d", m_sig_t, filtered_out, m_sig + 4); end
      end
    end
  endtask

  task automatic test_turnpoints();
    int peaks;
    noise_en = 1'b0;
    do_reset(1);
    peaks = 0;
    while (m_t <= 2046) begin
      step();
      if (signal == 10'd1023) peaks++;
      if (m_sig_t == 1024) begin
        n_cmp++;
        if (signal !== 10'd1022) begin n_err++; $display("FAIL after_peak: got %0d expected 1022", signal); end
      end
      if (m_sig_t == 2046) begin
        n_cmp++;
        if (signal !== 10'd0) begin n_err++; $display("FAIL period_return: got %0d expected 0", signal); end
      end
    end
    n_cmp++;
    if (peaks != 1) begin n_err++; $display("FAIL peak_count: got %0d expected 1", peaks); end
  endtask

  task automatic test_noise_zero();
    noise_en = 1'b1; noise_level = 4'd0;
    do_reset(1);
    repeat (300) begin
      step();
      n_cmp++;
      if (signal !== 10'(m_clean)) begin n_err++; $display("FAIL level0_signal: t %0d got %0d expected %0d", m_sig_t, signal, m_clean); end
      n_cmp++;
      if (filtered_out !== 10'(m_filt)) begin n_err++; $display("FAIL level0_filt: t %0d got %0d expected %0d", m_sig_t, filtered_out, m_filt); end
    end
  endtask

  task automatic test_noise_level();
    int d;
    noise_en = 1'b1; noise_level = 4'd10;
    do_reset(1);
    repeat (600) begin
      step();
      d = int'(signal) - m_clean;
      if (d < 0) d = -d;
      n_cmp++;
      if (d > 160) begin n_err++; $display("FAIL level10_bound: t %0d got |dev| %0d expected <= 160", m_sig_t, d); end
      n_cmp++;
      if (signal !== 10'(m_sig)) begin n_err++; $display("FAIL level10_signal: t %0d got %0d expected %0d", m_sig_t, signal, m_sig); end
    end
    repeat (300) begin
      noise_en = 1'($urandom_range(0, 1));
      noise_level = 4'($urandom_range(0, 15));
      step();
      n_cmp++;
      if (signal !== 10'(m_sig)) begin n_err++; $display("FAIL rand_signal: t %0d got %0d expected %0d", m_sig_t, signal, m_sig); end
      n_cmp++;
      if (filtered_out !== 10'(m_filt)) begin n_err++; $display("FAIL rand_filt: t %0d got %0d expected %0d", m_sig_t, filtered_out, m_filt); end
    end
  endtask

  task automatic test_clamp();
    bit   saw_hi;
    bit   saw_lo;
    real  ss, ss2, fs, fs2, rs, rf, var_s, var_f;
    int   cnt;
    noise_en = 1'b1; noise_level = 4'd15;
    do_reset(1);
    saw_hi = 0; saw_lo = 0; ss = 0; ss2 = 0; fs = 0; fs2 = 0; cnt = 0;
    while (m_t < 2100) begin
      step();
      n_cmp++;
      if (signal !== 10'(m_sig)) begin n_err++; $display("FAIL clamp_signal: t %0d got %0d expected %0d", m_sig_t, signal, m_sig); end
      n_cmp++;
      if (filtered_out !== 10'(m_filt)) begin n_err++; $display("FAIL clamp_filt: t %0d got %0d expected %0d", m_sig_t, filtered_out, m_filt); end
      if (m_clean > 900 && signal == 10'd1023) saw_hi = 1;
      if (m_clean < 100 && m_sig_t > 1500 && signal == 10'd0) saw_lo = 1;
      if (m_sig_t >= 16) begin
        rs = real'(int'(signal)) - real'(m_clean);
        rf = real'(int'(filtered_out)) - real'(m_clean_filt);
        ss += rs; ss2 += rs * rs; fs += rf; fs2 += rf * rf; cnt++;
      end
    end
    n_cmp++;
    if (!saw_hi) begin n_err++; $display("FAIL clamp_high: got no 1023 near peak expected saturation"); end
    n_cmp++;
    if (!saw_lo) begin n_err++; $display("FAIL clamp_low: got no 0 near trough expected saturation"); end
    var_s = ss2 / cnt - (ss / cnt) * (ss / cnt);
    var_f = fs2 / cnt - (fs / cnt) * (fs / cnt);
    n_cmp++;
    if (!(var_f * 2.0 < var_s)) begin n_err++; $display("FAIL variance: got filt %f expected well below signal %f", var_f, var_s); end
  endtask

  task automatic test_mid_reset();
    noise_en = 1'b1; noise_level = 4'd7;
    do_reset(1);
    repeat (137) step();
    do_reset(1);
    n_cmp++;
    if (signal !== 10'd0) begin n_err++; $display("FAIL midreset_signal: got %0d expected 0", signal); end
    n_cmp++;
    if (filtered_out !== 10'd0) begin n_err++; $display("FAIL midreset_filt: got %0d expected 0", filtered_out); end
    repeat (40) begin
      step();
      n_cmp++;
      if (signal !== 10'(m_sig)) begin n_err++; $display("FAIL restart_signal: t %0d got %0d expected %0d", m_sig_t, signal, m_sig); end
      n_cmp++;
      if (filtered_out !== 10'(m_filt)) begin n_err++; $display("FAIL restart_filt: t %0d got %0d expected %0d", m_sig_t, filtered_out, m_filt); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_filter();
    test_turnpoints();
    test_noise_zero();
    test_noise_level();
    test_clamp();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
